// File: rtl/ultrasonic_ranger_pkg.sv
// Shared types for the ultrasonic ranger: FSM state encoding and synchronizer depth.
package ultrasonic_ranger_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TRIG,
      WAIT,
      MEAS,
      DONE,
      HOLD
   } state_e;

   localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/ultrasonic_ranger_echo_sync.sv
// Echo input synchronizer with registered rise/fall flags aligned to dout.
module echo_sync
   import ultrasonic_ranger_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rise_q;
   logic                   fall_q;

   // Edges are computed from the value about to enter the last stage, so the
   // flags assert in the same cycle dout changes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         rise_q <= sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
         fall_q <= ~sync_q[SYNC_STAGES-2] & sync_q[SYNC_STAGES-1];
      end
   end

   assign dout = sync_q[SYNC_STAGES-1];
   assign rise = rise_q;
   assign fall = fall_q;

endmodule

// File: rtl/ultrasonic_ranger.sv
// Ultrasonic ranger: trigger, echo width measurement, obstacle threshold compare.
// Optional DEBOUNCE_EN filters obstacle_detect over DEB_COUNT consecutive samples.
module ultrasonic_ranger
   import ultrasonic_ranger_pkg::*;
#(
   parameter int W_W          = 16,
   parameter int TRIG_CYCLES  = 10,
   parameter int ECHO_TIMEOUT = 30000,
   parameter int HOLDOFF      = 5000,
   parameter int DEB_COUNT    = 3
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           enable,
   input  logic           echo,
   input  logic [W_W-1:0] threshold,
   output logic           trig,
   output logic [W_W-1:0] echo_width,
   output logic           sample_valid,
   output logic           timeout_err,
   output logic           obstacle_detect
);

   localparam logic [W_W-1:0] TRIG_LAST = W_W'(TRIG_CYCLES - 1);
   localparam logic [W_W-1:0] TMO_LAST  = W_W'(ECHO_TIMEOUT - 1);
   localparam logic [W_W-1:0] TMO_MAX   = W_W'(ECHO_TIMEOUT);
   localparam logic [W_W-1:0] HOLD_LAST = W_W'(HOLDOFF - 1);

   state_e         state_q;
   logic [W_W-1:0] cnt_q;
   logic [W_W-1:0] wid_q;
   logic           tmo_q;
   logic           trig_q;
   logic           sv_q;
   logic [W_W-1:0] ew_q;
   logic           te_q;
   logic           obst_q;
   logic           obs_d;
   logic           echo_s;
   logic           echo_rise;
   logic           echo_fall;

`ifdef DEBOUNCE_EN
   localparam int             DEB_W    = $clog2(DEB_COUNT + 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_COUNT - 1);
   logic [DEB_W-1:0] deb_q;
`endif

   echo_sync u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (echo),
      .dout    (echo_s),
      .rise    (echo_rise),
      .fall    (echo_fall)
   );

   assign obs_d = !tmo_q && (wid_q < threshold);

   // cnt_q is shared between TRIG, WAIT and HOLD; each entry reloads it to 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wid_q   <= '0;
         tmo_q   <= 1'b0;
         trig_q  <= 1'b0;
         sv_q    <= 1'b0;
         ew_q    <= '0;
         te_q    <= 1'b0;
         obst_q  <= 1'b0;
`ifdef DEBOUNCE_EN
         deb_q   <= '0;
`endif
      end else if (!enable) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wid_q   <= '0;
         tmo_q   <= 1'b0;
         trig_q  <= 1'b0;
         sv_q    <= 1'b0;
         obst_q  <= 1'b0;
`ifdef DEBOUNCE_EN
         deb_q   <= '0;
`endif
      end else begin
         sv_q <= 1'b0;
         case (state_q)
            IDLE: begin
               state_q <= TRIG;
               trig_q  <= 1'b1;
               cnt_q   <= '0;
            end
            TRIG: begin
               if (cnt_q == TRIG_LAST) begin
                  state_q <= WAIT;
                  trig_q  <= 1'b0;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            // Only a fresh rise starts MEAS; an echo already high stays ignored.
            WAIT: begin
               if (echo_rise) begin
                  state_q <= MEAS;
                  wid_q   <= W_W'(1);
                  tmo_q   <= 1'b0;
               end else if (cnt_q == TMO_LAST) begin
                  state_q <= DONE;
                  wid_q   <= TMO_MAX;
                  tmo_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            MEAS: begin
               if (echo_fall || (wid_q == TMO_MAX)) begin
                  state_q <= DONE;
               end else begin
                  wid_q <= wid_q + 1'b1;
               end
            end
            DONE: begin
               state_q <= HOLD;
               cnt_q   <= '0;
               sv_q    <= 1'b1;
               ew_q    <= wid_q;
               te_q    <= tmo_q;
`ifdef DEBOUNCE_EN
               if (obs_d == obst_q) begin
                  deb_q <= '0;
               end else if (deb_q == DEB_LAST) begin
                  obst_q <= obs_d;
                  deb_q  <= '0;
               end else begin
                  deb_q <= deb_q + 1'b1;
               end
`else
               obst_q <= obs_d;
`endif
            end
            HOLD: begin
               if (cnt_q == HOLD_LAST) begin
                  state_q <= TRIG;
                  trig_q  <= 1'b1;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign trig            = trig_q;
   assign echo_width      = ew_q;
   assign sample_valid    = sv_q;
   assign timeout_err     = te_q;
   assign obstacle_detect = obst_q;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger; DEBOUNCE_EN selects the debounce sequence.
module tb_ultrasonic_ranger;

   logic        clk;
   logic        reset_n;
   logic        enable;
   logic        echo;
   logic [15:0] threshold;
   logic        trig;
   logic [15:0] echo_width;
   logic        sample_valid;
   logic        timeout_err;
   logic        obstacle_detect;

   int checks   = 0;
   int failures = 0;

   ultrasonic_ranger dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .enable          (enable),
      .echo            (echo),
      .threshold       (threshold),
      .trig            (trig),
      .echo_width      (echo_width),
      .sample_valid    (sample_valid),
      .timeout_err     (timeout_err),
      .obstacle_detect (obstacle_detect)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic expired(input string tag, input int n, input int max);
      if (n >= max) begin
         checks++;
         failures++;
         $display("FAIL %s wait expired after %0d cycles", tag, n);
      end
   endtask

   task automatic wait_trig(input string tag, input int max, output int n);
      n = 0;
      while (trig !== 1'b1 && n < max) begin
         @(negedge clk);
         n++;
      end
      expired(tag, n, max);
   endtask

   task automatic count_high(output int n);
      n = 0;
      while (trig === 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic wait_sv(input string tag, input int max, output int n);
      n = 0;
      while (sample_valid !== 1'b1 && n < max) begin
         @(negedge clk);
         n++;
      end
      expired(tag, n, max);
   endtask

   task automatic echo_pulse(input int w);
      echo = 1'b1;
      repeat (w) @(negedge clk);
      echo = 1'b0;
   endtask

   task automatic restart();
      enable = 1'b0;
      @(negedge clk);
      enable = 1'b1;
   endtask

   // One full measurement from trigger start; leaves the bench on the sample_valid cycle.
   task automatic measure(input string tag, input int w);
      int n;
      wait_trig({tag, "_trig"}, 6000, n);
      count_high(n);
      chk({tag, "_trig_len"}, n, 10);
      echo_pulse(w);
      wait_sv({tag, "_sv"}, 2000, n);
   endtask

`ifdef DEBOUNCE_EN
   int widths [6] = '{500, 500, 2000, 500, 500, 500};
   int exp_od [6] = '{0, 0, 0, 0, 0, 1};
`endif

   initial begin
      int n;
      reset_n   = 1'b0;
      enable    = 1'b0;
      echo      = 1'b0;
      threshold = 16'd1000;
      repeat (2) @(negedge clk);
      chk("rst_trig", trig, 0);
      chk("rst_sv", sample_valid, 0);
      chk("rst_width", echo_width, 0);
      chk("rst_tmo", timeout_err, 0);
      chk("rst_obst", obstacle_detect, 0);
      reset_n = 1'b1;
      @(negedge clk);
      enable = 1'b1;

`ifdef DEBOUNCE_EN
      for (int i = 0; i < 6; i++) begin
         measure($sformatf("deb%0d", i), widths[i]);
         chk($sformatf("deb%0d_width", i), echo_width, widths[i]);
         chk($sformatf("deb%0d_obst", i), obstacle_detect, exp_od[i]);
      end
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("deb_rst_obst", obstacle_detect, 0);
      chk("deb_rst_width", echo_width, 0);
      chk("deb_rst_trig", trig, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("deb_rst_sv", sample_valid, 0);
`else
      // Timeout: no echo at all.
      wait_trig("t1_trig", 20, n);
      chk("t1_trig_lat", n, 1);
      count_high(n);
      chk("t1_trig_len", n, 10);
      wait_sv("t1_sv", 31000, n);
      chk("t1_wait_len", n, 30001);
      chk("t1_tmo", timeout_err, 1);
      chk("t1_width", echo_width, 30000);
      chk("t1_obst", obstacle_detect, 0);
      wait_trig("t1_hold", 6000, n);
      chk("t1_holdoff", n, 5000);

      // 500-cycle echo, threshold 1000.
      count_high(n);
      chk("t2_trig_len", n, 10);
      echo_pulse(500);
      wait_sv("t2_sv", 2000, n);
      chk("t2_width", echo_width, 500);
      chk("t2_tmo", timeout_err, 0);
      chk("t2_obst", obstacle_detect, 1);
      @(negedge clk);
      chk("t2_sv_pulse", sample_valid, 0);

      // Threshold boundary: 1000 is not below 1000, 999 is.
      restart();
      measure("t3a", 1000);
      chk("t3a_width", echo_width, 1000);
      chk("t3a_obst", obstacle_detect, 0);
      restart();
      measure("t3b", 999);
      chk("t3b_width", echo_width, 999);
      chk("t3b_obst", obstacle_detect, 1);

      // Abort mid-MEAS after the natural holdoff.
      wait_trig("t5_trig", 6000, n);
      count_high(n);
      echo = 1'b1;
      repeat (100) @(negedge clk);
      chk("t5_obst_before", obstacle_detect, 1);
      enable = 1'b0;
      echo   = 1'b0;
      @(negedge clk);
      chk("t5_trig", trig, 0);
      chk("t5_obst", obstacle_detect, 0);
      chk("t5_width_held", echo_width, 999);
      n = 0;
      for (int i = 0; i < 50; i++) begin
         if (sample_valid === 1'b1) n++;
         @(negedge clk);
      end
      chk("t5_no_sv", n, 0);
      enable = 1'b1;
      @(negedge clk);
      chk("t5_fresh_trig", trig, 1);

      // Saturation: echo held high well past ECHO_TIMEOUT.
      count_high(n);
      chk("t4_trig_len", n, 10);
      echo = 1'b1;
      wait_sv("t4_sv", 40000, n);
      echo = 1'b0;
      chk("t4_width", echo_width, 30000);
      chk("t4_tmo", timeout_err, 0);
      chk("t4_obst", obstacle_detect, 0);

      // threshold=0 never flags.
      threshold = 16'd0;
      restart();
      measure("thr0", 500);
      chk("thr0_width", echo_width, 500);
      chk("thr0_obst", obstacle_detect, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
